// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcode, ALU, mux-select and state encodings for the multi-cycle control unit
package cpu_ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  // ALU operation select
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  // PC source mux
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Register-file destination mux
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;

  // Controller states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  // True for every opcode the controller knows how to sequence
  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_ADDI, OP_ANDI, OP_ORI: isLegalOp = 1'b1;
      default:                        isLegalOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - bounded wait counter flagging a memory request stuck without ready
module mem_wait_ctr #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic restart,
  output logic expired
);

  // MEM_TIMEOUT = 0 disables the check; keep a 1-bit counter so widths stay legal
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] waitCnt;

  // Count cycles of an outstanding request; saturate at the limit so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (restart || ready) begin
      waitCnt <= '0;
    end else if (req && (waitCnt != LIMIT)) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Expired only means "limit reached"; the FSM lets a same-cycle ready win
  assign expired = (MEM_TIMEOUT != 0) && (waitCnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FSM sequencing fetch/decode/execute/memory/write-back
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             ext_sel,
  output logic             alu_b_src,
  output logic [3:0]       op_sel,
  output logic             wb_src,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  logic [2:0] state;
  logic [2:0] nextState;
  logic       retire;
  logic       expired;
  logic       restart;

  // A fresh wait window opens whenever a memory state is newly entered
  assign restart = ((nextState == S_FETCH) || (nextState == S_MEM)) && (nextState != state);

  mem_wait_ctr #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_waitCtr (
    .clk    (clk),
    .rst_n  (rst),
    .req    (mem_req),
    .ready  (mem_ready),
    .restart(restart),
    .expired(expired)
  );

  // Next-state and datapath control decode; every strobe defaults low
  always_comb begin
    nextState = state;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    reg_dst   = DST_RT;
    ext_sel   = 1'b0;
    alu_b_src = 1'b0;
    op_sel    = ALU_AND;
    wb_src    = 1'b0;
    case (state)
      S_IDLE: nextState = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_PLUS4;
          nextState = S_DECODE;
        end else if (expired) begin
          nextState = S_FAULT;
        end
      end
      S_DECODE: nextState = isLegalOp(opcode) ? S_EXEC : S_FAULT;
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            op_sel    = ALU_FUNCT;
            nextState = S_WB;
          end
          OP_ADDI: begin
            op_sel    = ALU_ADD;
            alu_b_src = 1'b1;
            ext_sel   = 1'b1;
            nextState = S_WB;
          end
          OP_ANDI, OP_ORI: begin
            op_sel    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            alu_b_src = 1'b1;
            nextState = S_WB;
          end
          OP_LW, OP_SW: begin
            op_sel    = ALU_ADD;
            alu_b_src = 1'b1;
            ext_sel   = 1'b1;
            nextState = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            op_sel    = ALU_SUB;
            pc_src    = PC_BRANCH;
            pc_write  = (opcode == OP_BEQ) ? zero : !zero;
            nextState = S_FETCH;
            retire    = 1'b1;
          end
          OP_J: begin
            pc_src    = PC_JUMP;
            pc_write  = 1'b1;
            nextState = S_FETCH;
            retire    = 1'b1;
          end
          // Opcode changed under us after decode: treat as illegal
          default: nextState = S_FAULT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            nextState = S_FETCH;
            retire    = 1'b1;
          end else begin
            nextState = S_WB;
          end
        end else if (expired) begin
          nextState = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R) ? DST_RD : DST_RT;
        wb_src    = (opcode == OP_LW);
        nextState = S_FETCH;
        retire    = 1'b1;
      end
      S_FAULT: nextState = S_FAULT;
      default: nextState = S_FAULT;
    endcase
  end

  // State register; FAULT is only left through reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Sticky fault flag, raised on the edge that enters FAULT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault <= 1'b0;
    end else if (nextState == S_FAULT) begin
      fault <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
  logic        ext_sel, alu_b_src, wb_src, fault;
  logic [1:0]  pc_src, reg_dst;
  logic [3:0]  op_sel;
  logic [31:0] retired;
  logic [16:0] strobes;

  logic [5:0] opTable [9] = '{R, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI};

  int nChecks = 0;
  int nPass   = 0;

  assign strobes = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
                    reg_dst, ext_sel, alu_b_src, op_sel, wb_src};

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .ext_sel(ext_sel), .alu_b_src(alu_b_src), .op_sel(op_sel), .wb_src(wb_src),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Run one instruction starting in the first FETCH cycle (time = posedge + 1).
  // Fetch is answered after w1 wait cycles, the data access after w2.
  task automatic runInstr(input logic [5:0] op, input logic z, input int w1, input int w2,
                          input string nm);
    int cyc = 0, reqCnt = 0, irw = 0, pcw = 0, rw = 0, iod = 0, we = 0, memCyc = 0;
    logic [1:0]  lastPcSrc = 2'b00, dst = 2'b00;
    logic        wbs = 1'b0, aluB = 1'b0, ext = 1'b0, taken, isLs, writesReg;
    logic [3:0]  opOr = 4'b0000, expOp;
    logic [31:0] startRet = retired;
    bit          done = 0;
    isLs      = (op == LW) || (op == SW);
    taken     = ((op == BEQ) && z) || ((op == BNE) && !z);
    writesReg = (op == R) || (op == ADDI) || (op == ANDI) || (op == ORI) || (op == LW);
    expOp     = (op == R) ? 4'hF : (op == ORI) ? 4'h1 : ((op == BEQ) || (op == BNE)) ? 4'h6 :
                ((op == ADDI) || isLs) ? 4'h2 : 4'h0;
    opcode = op;
    zero   = z;
    while (!done && cyc < 40) begin
      mem_ready = mem_req && (reqCnt == (i_or_d ? w2 : w1));
      @(negedge clk);
      cyc++;
      if (ir_write) irw++;
      if (pc_write) begin pcw++; lastPcSrc = pc_src; end
      if (reg_write) begin rw++; dst = reg_dst; wbs = wb_src; end
      if (mem_req) memCyc++;
      if (mem_req && i_or_d) iod++;
      if (mem_we) we++;
      opOr = opOr | op_sel;
      aluB = aluB | alu_b_src;
      ext  = ext | ext_sel;
      if (mem_req) reqCnt = mem_ready ? 0 : reqCnt + 1;
      else reqCnt = 0;
      @(posedge clk); #1;
      done = (retired != startRet);
    end
    mem_ready = 1'b0;
    checkVal({nm, ".cycles"}, cyc, ((op == LW) ? 5 : (op == BEQ || op == BNE || op == J) ? 3 : 4)
             + w1 + (isLs ? w2 : 0));
    checkVal({nm, ".retired"}, retired, startRet + 1);
    checkVal({nm, ".ir_write"}, irw, 1);
    checkVal({nm, ".pc_writes"}, pcw, 1 + ((op == J) ? 1 : 0) + (taken ? 1 : 0));
    checkVal({nm, ".pc_src"}, lastPcSrc, (op == J) ? 2 : taken ? 1 : 0);
    checkVal({nm, ".reg_write"}, rw, writesReg ? 1 : 0);
    checkVal({nm, ".reg_dst"}, dst, (op == R) ? 1 : 0);
    checkVal({nm, ".wb_src"}, wbs, (op == LW) ? 1 : 0);
    checkVal({nm, ".mem_cycles"}, memCyc, w1 + 1 + (isLs ? w2 + 1 : 0));
    checkVal({nm, ".i_or_d"}, iod, isLs ? w2 + 1 : 0);
    checkVal({nm, ".mem_we"}, we, (op == SW) ? w2 + 1 : 0);
    checkVal({nm, ".op_sel"}, opOr, expOp);
    checkVal({nm, ".alu_b_src"}, aluB, (isLs || op == ADDI || op == ANDI || op == ORI) ? 1 : 0);
    checkVal({nm, ".ext_sel"}, ext, (isLs || op == ADDI) ? 1 : 0);
    checkVal({nm, ".fault"}, fault, 0);
  endtask

  // Called at posedge + 1 while reset is held: release it, then step IDLE into FETCH
  task automatic releaseReset();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int memCyc;
    logic [5:0] op;
    logic [31:0] retBefore;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset.retired", retired, 0);
    checkVal("reset.fault", fault, 0);
    checkVal("reset.strobes", strobes, 0);
    rst = 1'b1;
    @(negedge clk);
    checkVal("idle.strobes", strobes, 0);
    @(posedge clk); #1;

    // Directed instructions
    runInstr(ADDI, 1'b0, 0, 0, "addi");
    runInstr(LW, 1'b0, 3, 3, "lw33");
    runInstr(BEQ, 1'b1, 0, 0, "beq_t");
    runInstr(BEQ, 1'b0, 0, 0, "beq_n");
    runInstr(BNE, 1'b1, 0, 0, "bne_n");
    runInstr(BNE, 1'b0, 0, 0, "bne_t");
    runInstr(SW, 1'b0, TMO, TMO, "sw_edge");
    runInstr(R, 1'b0, 1, 0, "r");
    runInstr(J, 1'b0, 0, 0, "j");

    // Randomized instruction stream; waits span 0..TMO
    for (int i = 0; i < 30; i++) begin
      op = opTable[$urandom_range(0, 8)];
      runInstr(op, 1'($urandom_range(0, 1)), $urandom_range(0, TMO), $urandom_range(0, TMO),
               $sformatf("rnd%0d_%b", i, op));
    end

    // Reset asserted while a data access is outstanding
    opcode = LW;
    cyc = 0;
    while (!(mem_req && i_or_d) && cyc < 20) begin
      mem_ready = mem_req;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ready = 1'b0;
    checkVal("rstmid.reached_mem", {31'd0, mem_req && i_or_d}, 1);
    #2 rst = 1'b0;
    #1;
    checkVal("rstmid.strobes", strobes, 0);
    checkVal("rstmid.retired", retired, 0);
    checkVal("rstmid.fault", fault, 0);
    @(posedge clk); #1;
    releaseReset();
    runInstr(ORI, 1'b0, 0, 0, "ori_after_rst");

    // Data access never answered: FAULT after TMO+1 MEM cycles
    opcode = LW;
    retBefore = retired;
    cyc = 0;
    memCyc = 0;
    while (!fault && cyc < 30) begin
      mem_ready = mem_req && !i_or_d;
      @(negedge clk);
      cyc++;
      if (mem_req && i_or_d) memCyc++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    checkVal("tmo.mem_cycles", memCyc, TMO + 1);
    checkVal("tmo.fault", fault, 1);
    repeat (3) @(posedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    checkVal("tmo.sticky", fault, 1);
    checkVal("tmo.strobes", strobes, 0);
    checkVal("tmo.retired", retired, retBefore);
    mem_ready = 1'b0;

    // Asynchronous reset in the middle of FAULT
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkVal("rstfault.fault", fault, 0);
    checkVal("rstfault.retired", retired, 0);
    checkVal("rstfault.strobes", strobes, 0);
    @(posedge clk); #1;
    releaseReset();

    // Illegal opcode: FETCH, DECODE, then FAULT
    opcode = 6'b111111;
    cyc = 0;
    while (!fault && cyc < 20) begin
      mem_ready = mem_req;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ready = 1'b0;
    checkVal("illegal.cycles", cyc, 2);
    checkVal("illegal.fault", fault, 1);
    @(negedge clk);
    checkVal("illegal.strobes", strobes, 0);
    #2 rst = 1'b0;
    #1;
    checkVal("illegal.rst_fault", fault, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the MIPS-style core: replaces the single-cycle combinational control path with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. Memory uses a req/ready handshake with a bounded wait, so the core can share one variable-latency memory port. A stuck access is trapped into a sticky fault state, and a counter records retired instructions. It drives the existing datapath control lines (`pc_src`, `reg_dst`, `op_sel`, and the rest) and sits between the instruction register and the datapath.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles `mem_req` may stay high without `mem_ready`; 0 disables the timeout.
- `CNT_W`, 32: width of `retired`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], stable from the cycle after `ir_write`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, valid with `mem_req`.
- `i_or_d` out 1: address select; 0 = PC, 1 = ALU result.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: update the PC.
- `pc_src` out 2: 00 = PC+4, 01 = branch target, 10 = jump target.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 2: 00 = rt, 01 = rd.
- `ext_sel` out 1: 1 = sign-extend, 0 = zero-extend.
- `alu_b_src` out 1: 0 = register, 1 = immediate.
- `op_sel` out 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 ALU decodes funct.
- `wb_src` out 1: 0 = ALU, 1 = memory data.
- `fault` out 1: sticky, set on illegal opcode or timeout.
- `retired` out CNT_W: count of completed instructions, wraps at 2^CNT_W.

## Operation
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, ADDI 001000, ANDI 001100, ORI 001101.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. Every output not listed for a state is 0.
- IDLE: reset state. All outputs are 0. Goes unconditionally to FETCH.
- FETCH:
  - `mem_req` = 1, `i_or_d` = 0.
  - While waiting, stays in FETCH.
  - On `mem_ready`: `ir_write` = 1, `pc_write` = 1, `pc_src` = 00, go to DECODE.
- DECODE: illegal opcode goes to FAULT; otherwise goes to EXEC.
- EXEC:
  - R: `op_sel` = 1111, go to WB.
  - ADDI: `op_sel` = 0010, `alu_b_src` = 1, `ext_sel` = 1, go to WB.
  - ANDI / ORI: `op_sel` = 0000 / 0001, `alu_b_src` = 1, `ext_sel` = 0, go to WB.
  - LW / SW: `op_sel` = 0010, `alu_b_src` = 1, `ext_sel` = 1, go to MEM.
  - BEQ / BNE: `op_sel` = 0110, `pc_src` = 01, `pc_write` = `zero` (BEQ) or `!zero` (BNE), go to FETCH, retire.
  - J: `pc_src` = 10, `pc_write` = 1, go to FETCH, retire.
- MEM:
  - `mem_req` = 1, `i_or_d` = 1, `mem_we` = (opcode == SW).
  - On `mem_ready`: SW goes to FETCH and retires; LW goes to WB.
- WB:
  - `reg_write` = 1.
  - `reg_dst` = 01 for R, 00 otherwise.
  - `wb_src` = 1 for LW, 0 otherwise.
  - Go to FETCH, retire.
- FAULT: absorbing; all strobes are 0 and `fault` = 1. It is left only by reset.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM and on `mem_ready`, and increments each cycle `mem_req` = 1 without `mem_ready`.
  - When the count reaches MEM_TIMEOUT with no `mem_ready` in that cycle, the next state is FAULT.
  - A `mem_ready` in the same cycle wins.

## Timing
- Outputs are combinational from the state register plus `opcode`, `zero` and `mem_ready`; the state register, wait counter, `fault` and `retired` are registered.
- Zero-wait latency per instruction:
  - R / ADDI / ANDI / ORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ / BNE / J: 3 cycles.
- Each wait cycle adds 1.
- Reset asserted mid-instruction: the next state is IDLE immediately. `fault` = 0, `retired` = 0, wait counter = 0, and all strobes drop in the same cycle.
- `retired` increments on the clock edge that leaves the final state of an instruction: EXEC for branch/J, MEM for SW, WB for the rest.

## Structure
- Shared package `cpu_ctrl_pkg`: opcode constants, `op_sel` codes, `pc_src`/`reg_dst` encodings, and the state enum (3 bits).
- One sub-module, `mem_wait_ctr`: parametrised by MEM_TIMEOUT; inputs `req`, `ready`, `restart`; output `expired`.

## Test plan
- Reset release, then ADDI with `mem_ready` tied 1:
  - States: IDLE, FETCH, DECODE, EXEC, WB.
  - `reg_write` = 1 in WB, `reg_dst` = 00.
  - `retired` = 1 after the 5th edge.
- LW with 3 wait cycles on both accesses:
  - Total 11 cycles.
  - `wb_src` = 1 and `reg_write` = 1 in WB.
  - `i_or_d` = 1 only in MEM.
- BEQ:
  - `zero` = 1 gives `pc_write` = 1 with `pc_src` = 01.
  - `zero` = 0 gives `pc_write` = 0.
  - BNE gives the inverse.
  - `retired` increments in every case.
- Timeout: with MEM_TIMEOUT = 4, hold `mem_ready` = 0 in MEM; FAULT is entered after 5 cycles and `fault` stays 1; `mem_ready` arriving in the 5th cycle instead avoids the fault.
- Opcode 111111 leads to FAULT after DECODE; then `rst` = 0 mid-FAULT clears `fault` and `retired` asynchronously and returns the FSM to IDLE.
